// File: rtl/usb_pkg.sv
// Shared FSM state encoding and encoder packet-select codes for the host transaction sequencer.
// Pure type/constant package: no latency, no flow control.
package usb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        TX_WAIT   = 3'd2,
        WAIT_RESP = 3'd3,
        SEND_ACK  = 3'd4,
        ACK_WAIT  = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam logic [1:0] SEL_TOKEN_DATA = 2'b00;
    localparam logic [1:0] SEL_TOKEN      = 2'b01;
    localparam logic [1:0] SEL_ACK        = 2'b10;

endpackage

// File: rtl/timeout_counter.sv
// Response timer: counts enabled cycles; expired is combinational on the last allowed cycle.
// Latency: clear/enable take effect next edge; saturates at TIMEOUT_CYCLES, no backpressure.
module timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            timer <= '0;
        end else if (enable && (timer != LIMIT)) begin
            timer <= timer + TW'(1);
        end
    end

    assign expired = enable && (timer == LAST);

endmodule

// File: rtl/txn_retry_sequencer.sv
// Host transaction sequencer: send token, await response, retry up to MAX_RETRY attempts, ACK IN data.
// Latency: all outputs registered, one cycle after the causing input; encoder paced by tx_done pulses.
module txn_retry_sequencer
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       txn_in,
    input  logic       tx_done,
    input  logic       ACK_rec,
    input  logic       NAK_rec,
    input  logic       DATA0_rec,
    input  logic       crc_ok,
    output logic       send_pkt,
    output logic [1:0] send_sel,
    output logic       host_sending,
    output logic       rx_armed,
    output logic       busy,
    output logic       done,
    output logic       success,
    output logic [3:0] retry_cnt
);

    localparam logic [4:0] RETRY_LIMIT = 5'(MAX_RETRY);

    state_t     state;
    logic       txn_is_in;
    logic       expired;
    logic       any_resp;
    logic       resp_good;
    logic       give_up;
    logic [1:0] token_sel;

    timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state != WAIT_RESP),
        .enable (state == WAIT_RESP),
        .expired(expired)
    );

    // ACK outranks DATA0, so an IN transaction seeing both treats it as a bad response.
    assign any_resp  = ACK_rec | NAK_rec | DATA0_rec;
    assign resp_good = txn_is_in ? (DATA0_rec & crc_ok & ~ACK_rec) : ACK_rec;
    assign give_up   = (({1'b0, retry_cnt} + 5'd1) == RETRY_LIMIT);
    assign token_sel = txn_is_in ? SEL_TOKEN : SEL_TOKEN_DATA;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            txn_is_in    <= 1'b0;
            retry_cnt    <= '0;
            send_pkt     <= 1'b0;
            send_sel     <= SEL_TOKEN_DATA;
            host_sending <= 1'b0;
            rx_armed     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            success      <= 1'b0;
        end else begin
            send_pkt <= 1'b0;
            send_sel <= SEL_TOKEN_DATA;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= SEND;
                        txn_is_in    <= txn_in;
                        retry_cnt    <= '0;
                        send_pkt     <= 1'b1;
                        send_sel     <= txn_in ? SEL_TOKEN : SEL_TOKEN_DATA;
                        host_sending <= 1'b1;
                        busy         <= 1'b1;
                        success      <= 1'b0;
                    end
                end
                SEND: begin
                    state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        state        <= WAIT_RESP;
                        host_sending <= 1'b0;
                        rx_armed     <= 1'b1;
                    end
                end
                WAIT_RESP: begin
                    // A response in the expiry cycle wins over the timeout.
                    if (resp_good) begin
                        rx_armed <= 1'b0;
                        if (txn_is_in) begin
                            state        <= SEND_ACK;
                            send_pkt     <= 1'b1;
                            send_sel     <= SEL_ACK;
                            host_sending <= 1'b1;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            success <= 1'b1;
                        end
                    end else if (any_resp || expired) begin
                        rx_armed <= 1'b0;
                        if (give_up) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            success <= 1'b0;
                        end else begin
                            state        <= SEND;
                            retry_cnt    <= retry_cnt + 4'd1;
                            send_pkt     <= 1'b1;
                            send_sel     <= token_sel;
                            host_sending <= 1'b1;
                        end
                    end
                end
                SEND_ACK: begin
                    state <= ACK_WAIT;
                end
                ACK_WAIT: begin
                    if (tx_done) begin
                        state        <= DONE;
                        host_sending <= 1'b0;
                        done         <= 1'b1;
                        success      <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    success <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    host_sending <= 1'b0;
                    rx_armed     <= 1'b0;
                    busy         <= 1'b0;
                    success      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_txn_retry_sequencer.sv
// Directed bench for txn_retry_sequencer built with MAX_RETRY=3, TIMEOUT_CYCLES=20.
// Inputs driven and outputs sampled on the falling edge.
module tb_txn_retry_sequencer;
    import usb_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       txn_in;
    logic       tx_done;
    logic       ACK_rec;
    logic       NAK_rec;
    logic       DATA0_rec;
    logic       crc_ok;
    logic       send_pkt;
    logic [1:0] send_sel;
    logic       host_sending;
    logic       rx_armed;
    logic       busy;
    logic       done;
    logic       success;
    logic [3:0] retry_cnt;

    int total = 0;
    int bad   = 0;
    int send_seen = 0;
    int n;
    int done_seen;

    always #5 clock = ~clock;

    txn_retry_sequencer #(
        .TIMEOUT_CYCLES(20),
        .MAX_RETRY     (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .txn_in      (txn_in),
        .tx_done     (tx_done),
        .ACK_rec     (ACK_rec),
        .NAK_rec     (NAK_rec),
        .DATA0_rec   (DATA0_rec),
        .crc_ok      (crc_ok),
        .send_pkt    (send_pkt),
        .send_sel    (send_sel),
        .host_sending(host_sending),
        .rx_armed    (rx_armed),
        .busy        (busy),
        .done        (done),
        .success     (success),
        .retry_cnt   (retry_cnt)
    );

    always @(negedge clock) if (send_pkt) send_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic start_txn(input logic is_in);
        start  = 1'b1;
        txn_in = is_in;
        step();
        start  = 1'b0;
        txn_in = 1'b0;
    endtask

    // Entered with a send_pkt cycle visible; leaves one cycle after tx_done is accepted.
    task automatic expect_send(input string tag, input logic [1:0] sel);
        chk({tag, ".pkt"}, send_pkt, 1);
        chk({tag, ".sel"}, send_sel, sel);
        chk({tag, ".hs"}, host_sending, 1);
        step();
        chk({tag, ".one"}, send_pkt, 0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic resp(input logic a, input logic nk, input logic d, input logic c);
        ACK_rec   = a;
        NAK_rec   = nk;
        DATA0_rec = d;
        crc_ok    = c;
        step();
        ACK_rec   = 1'b0;
        NAK_rec   = 1'b0;
        DATA0_rec = 1'b0;
        crc_ok    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; txn_in = 1'b0; tx_done = 1'b0;
        ACK_rec = 1'b0; NAK_rec = 1'b0; DATA0_rec = 1'b0; crc_ok = 1'b0;
        repeat (3) step();
        chk("rst.busy", busy, 0);
        chk("rst.pkt", send_pkt, 0);
        chk("rst.sel", send_sel, 0);
        chk("rst.hs", host_sending, 0);
        chk("rst.arm", rx_armed, 0);
        chk("rst.done", done, 0);
        chk("rst.succ", success, 0);
        chk("rst.retry", retry_cnt, 0);
        reset = 1'b0;
        step();

        // OUT, ACK ten cycles after tx_done; a stray start mid-transaction is ignored
        start_txn(1'b0);
        chk("o1.busy", busy, 1);
        expect_send("o1", SEL_TOKEN_DATA);
        chk("o1.arm", rx_armed, 1);
        chk("o1.hs0", host_sending, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("o1.ign", rx_armed, 1);
        repeat (8) step();
        resp(1, 0, 0, 0);
        chk("o1.done", done, 1);
        chk("o1.succ", success, 1);
        chk("o1.retry", retry_cnt, 0);
        step();
        chk("o1.pulse", done, 0);
        chk("o1.idle", busy, 0);

        // OUT, NAK twice then ACK
        send_seen = 0;
        start_txn(1'b0);
        expect_send("o2a", SEL_TOKEN_DATA);
        resp(0, 1, 0, 0);
        chk("o2.r1", retry_cnt, 1);
        expect_send("o2b", SEL_TOKEN_DATA);
        resp(0, 1, 0, 0);
        chk("o2.r2", retry_cnt, 2);
        expect_send("o2c", SEL_TOKEN_DATA);
        resp(1, 0, 0, 0);
        chk("o2.done", done, 1);
        chk("o2.succ", success, 1);
        chk("o2.retry", retry_cnt, 2);
        chk("o2.sends", send_seen, 3);
        repeat (2) step();
        chk("o2.hold", retry_cnt, 2);

        // IN, good DATA0 then host ACK
        start_txn(1'b1);
        expect_send("i1", SEL_TOKEN);
        resp(0, 0, 1, 1);
        expect_send("i1ack", SEL_ACK);
        chk("i1.done", done, 1);
        chk("i1.succ", success, 1);
        chk("i1.retry", retry_cnt, 0);
        step();

        // IN response priority: ACK beats DATA0, bad CRC retries, DATA0 beats NAK
        start_txn(1'b1);
        expect_send("p0", SEL_TOKEN);
        resp(1, 0, 1, 1);
        chk("p.ackwin", retry_cnt, 1);
        expect_send("p1", SEL_TOKEN);
        resp(0, 1, 1, 0);
        chk("p.badcrc", retry_cnt, 2);
        expect_send("p2", SEL_TOKEN);
        resp(0, 1, 1, 1);
        expect_send("pack", SEL_ACK);
        chk("p.succ", success, 1);
        chk("p.done", done, 1);
        step();

        // OUT exhausts retries: DATA0 then two NAKs
        start_txn(1'b0);
        expect_send("x0", SEL_TOKEN_DATA);
        resp(0, 0, 1, 1);
        expect_send("x1", SEL_TOKEN_DATA);
        resp(0, 1, 0, 0);
        expect_send("x2", SEL_TOKEN_DATA);
        resp(0, 1, 0, 0);
        chk("x.done", done, 1);
        chk("x.succ", success, 0);
        chk("x.retry", retry_cnt, 2);
        step();

        // IN with no response: three 20-cycle listen windows then failure
        start_txn(1'b1);
        for (int a = 0; a < 3; a++) begin
            expect_send($sformatf("to%0d", a), SEL_TOKEN);
            n = 0;
            while (rx_armed && n < 40) begin
                n++;
                step();
            end
            chk($sformatf("to%0d.arm", a), n, 20);
        end
        chk("to.done", done, 1);
        chk("to.succ", success, 0);
        chk("to.retry", retry_cnt, 2);
        step();

        // ACK arriving in the timeout cycle wins
        start_txn(1'b0);
        expect_send("ae", SEL_TOKEN_DATA);
        repeat (19) step();
        chk("ae.arm", rx_armed, 1);
        resp(1, 0, 0, 0);
        chk("ae.done", done, 1);
        chk("ae.succ", success, 1);
        chk("ae.retry", retry_cnt, 0);
        step();

        // Reset during WAIT_RESP aborts silently
        start_txn(1'b0);
        expect_send("r0", SEL_TOKEN_DATA);
        resp(0, 1, 0, 0);
        expect_send("r1", SEL_TOKEN_DATA);
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ra.busy", busy, 0);
        chk("ra.arm", rx_armed, 0);
        chk("ra.retry", retry_cnt, 0);
        chk("ra.hs", host_sending, 0);
        chk("ra.done", done, 0);
        done_seen = 0;
        ACK_rec = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            ACK_rec = 1'b0;
            if (done) done_seen++;
        end
        chk("ra.nodone", done_seen, 0);
        chk("ra.stay", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/txn_retry_sequencer.md
TXN_RETRY_SEQUENCER -- requirements
Module: txn_retry_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning: WAIT_RESP cycles allowed before a response timeout.
REQ-002 Parameter MAX_RETRY, default 8, range 1..15, meaning: total send attempts before failure.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  sole clock, all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  pulse; begin a transaction, sampled only in IDLE.
REQ-007 txn_in  in  1  captured at start; 1=IN transaction (expect DATA0), 0=OUT transaction (expect ACK/NAK).
REQ-008 tx_done  in  1  pulse from encoder; current host packet finished.
REQ-009 ACK_rec, NAK_rec, DATA0_rec  in  1 each  response pulses from the DP/DM decoder.
REQ-010 crc_ok  in  1  CRC16 good; qualified by DATA0_rec.
REQ-011 send_pkt  out  1  one-cycle request to the encoder.
REQ-012 send_sel  out  2  packet kind with send_pkt: 00=token+DATA0, 01=token only, 10=ACK handshake.
REQ-013 host_sending  out  1  high from the send_pkt cycle through the tx_done cycle.
REQ-014 rx_armed  out  1  high while in WAIT_RESP.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 success  out  1  valid with done; 1=completed, 0=retries exhausted.
REQ-018 retry_cnt  out  4  failed attempts in the current transaction.

Function
REQ-019 States SHALL be IDLE, SEND, TX_WAIT, WAIT_RESP, SEND_ACK, ACK_WAIT, DONE.
REQ-020 IDLE->SEND on start; txn_in latched; retry_cnt cleared.
REQ-021 SEND SHALL assert send_pkt for exactly one cycle with send_sel=01 if IN, else 00, then enter TX_WAIT.
REQ-022 TX_WAIT->WAIT_RESP on tx_done; timer cleared to 0 on entry.
REQ-023 In WAIT_RESP the timer SHALL increment each cycle; timeout fires when timer==TIMEOUT_CYCLES-1 with no response that cycle.
REQ-024 OUT: ACK_rec->DONE with success=1; NAK_rec, DATA0_rec or timeout->retry.
REQ-025 IN: DATA0_rec with crc_ok->SEND_ACK; DATA0_rec without crc_ok, NAK_rec, ACK_rec or timeout->retry.
REQ-026 Retry: if retry_cnt+1==MAX_RETRY go to DONE with success=0; otherwise increment retry_cnt and go to SEND.
REQ-027 SEND_ACK SHALL assert send_pkt one cycle with send_sel=10; ACK_WAIT->DONE with success=1 on tx_done.
REQ-028 DONE SHALL pulse done for one cycle, then return to IDLE; retry_cnt holds until next start.
REQ-029 A response pulse SHALL take precedence over a same-cycle timeout.
REQ-030 Simultaneous response pulses SHALL be prioritised ACK_rec > DATA0_rec > NAK_rec.
REQ-031 Response pulses outside WAIT_RESP, and start outside IDLE, SHALL be ignored.
REQ-032 The timer width SHALL be $clog2(TIMEOUT_CYCLES+1) and the timer SHALL never wrap inside WAIT_RESP.

Reset
REQ-033 Reset SHALL force IDLE, timer=0, retry_cnt=0, and send_pkt, send_sel, host_sending, rx_armed, busy, done, success all to 0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction without a done pulse.

Structure
REQ-035 The state enum and send_sel constants (SEL_TOKEN_DATA, SEL_TOKEN, SEL_ACK) SHALL live in shared package usb_pkg.
REQ-036 The response timer SHALL be one sub-module, timeout_counter, with clear, enable and expired ports.

Verification
REQ-037 OUT, ACK_rec 10 cycles after tx_done -> done=1, success=1, retry_cnt=0.
REQ-038 OUT, NAK twice then ACK -> three send_pkt pulses with send_sel=00; done with success=1, retry_cnt=2.
REQ-039 IN, DATA0_rec with crc_ok=1 -> send_pkt with send_sel=10; done with success=1 after tx_done.
REQ-040 IN, no response, MAX_RETRY=3, TIMEOUT_CYCLES=20 -> three attempts, each with rx_armed high for 20 cycles; done with success=0, retry_cnt=2.
REQ-041 ACK_rec on the timeout cycle -> success=1, no retry.
REQ-042 Reset in WAIT_RESP -> next cycle IDLE, all outputs 0, no done pulse.
